// File: rtl/test_rr_merge_sched_pkg.sv
// Shared definitions for the round-robin merge scheduler: buffer state
// encoding and requester-index width helper.
package test_rr_merge_sched_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_e;

  // Index width never drops below one bit, even for two requesters.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/test_rr_arb_core.sv
// Combinational round-robin grant: first requester at or after ptr,
// wrapping modulo p_num_reqs.
module test_rr_arb_core
  import test_rr_merge_sched_pkg::*;
#(
  parameter  int unsigned p_num_reqs  = 4,
  localparam int unsigned c_idx_nbits = idx_width(p_num_reqs)
) (
  input  logic [p_num_reqs-1:0]  req,
  input  logic [c_idx_nbits-1:0] ptr,
  output logic [p_num_reqs-1:0]  grant,
  output logic [c_idx_nbits-1:0] winner
);

  always_comb begin
    int unsigned idx;
    logic        found;
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 0; k < p_num_reqs; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= p_num_reqs) idx = idx - p_num_reqs;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        winner     = c_idx_nbits'(idx);
      end
    end
  end

endmodule

// File: rtl/test_rr_merge_sched.sv
// Shares one val/rdy sink among p_num_reqs requesters through a round-robin
// arbiter and a single-entry output buffer; counts deliveries and flags done.
module test_rr_merge_sched
  import test_rr_merge_sched_pkg::*;
#(
  parameter  int unsigned p_num_reqs  = 4,
  parameter  int unsigned p_msg_nbits = 32,
  parameter  int unsigned p_cnt_nbits = 32,
  localparam int unsigned c_idx_nbits = idx_width(p_num_reqs)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [p_cnt_nbits-1:0]            expected_total,
  input  logic [p_num_reqs-1:0]             in_val,
  output logic [p_num_reqs-1:0]             in_rdy,
  input  logic [p_num_reqs*p_msg_nbits-1:0] in_msg,
  output logic                              out_val,
  input  logic                              out_rdy,
  output logic [p_msg_nbits-1:0]            out_msg,
  output logic [c_idx_nbits-1:0]            out_src,
  output logic [p_cnt_nbits-1:0]            count,
  output logic                              done
);

  buf_state_e             state;
  logic [c_idx_nbits-1:0] ptr;
  logic [c_idx_nbits-1:0] winner;
  logic [p_num_reqs-1:0]  grant;
  logic                   can_accept;
  logic                   enq;
  logic                   deq;
  logic [p_cnt_nbits-1:0] count_next;

  test_rr_arb_core #(
    .p_num_reqs (p_num_reqs)
  ) u_arb (
    .req    (in_val),
    .ptr    (ptr),
    .grant  (grant),
    .winner (winner)
  );

  assign out_val    = (state == FULL);
  assign can_accept = (state == EMPTY) || out_rdy;
  // Reset gates in_rdy directly so no handshake is offered while held in reset.
  assign in_rdy     = reset ? '0 : (grant & {p_num_reqs{can_accept}});
  assign enq        = |(in_val & in_rdy);
  assign deq        = out_val && out_rdy;
  assign count_next = (deq && (count != '1)) ? count + p_cnt_nbits'(1) : count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= EMPTY;
      out_msg <= '0;
      out_src <= '0;
      ptr     <= '0;
      count   <= '0;
      done    <= 1'b0;
    end else begin
      count <= count_next;
      done  <= (count_next >= expected_total);
      if (enq) begin
        state   <= FULL;
        out_msg <= in_msg[winner*p_msg_nbits +: p_msg_nbits];
        out_src <= winner;
        ptr     <= (winner == c_idx_nbits'(p_num_reqs - 1)) ? '0
                                                            : winner + c_idx_nbits'(1);
      end else if (deq) begin
        state <= EMPTY;
      end
    end
  end

endmodule

// File: doc/test_rr_merge_sched.md
Name: test_rr_merge_sched

Overview:
- Test-harness scheduler that shares one downstream val/rdy sink among N independent requesters, such as several random-delay sources feeding one unordered sink.
- Round-robin arbitration feeds a single-entry registered output buffer.
- Tags each forwarded message with its source index.
- Counts delivered messages and raises done when an expected total has been delivered.

Parameters:
- p_num_reqs, 4, number of requester ports (2..16).
- p_msg_nbits, 32, message width per requester.
- p_cnt_nbits, 32, width of delivered-message counter and expected_total.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- expected_total  input  p_cnt_nbits  number of messages after which done asserts; sampled every cycle.
- in_val  input  p_num_reqs  per-requester valid.
- in_rdy  output  p_num_reqs  per-requester ready; at most one bit high per cycle.
- in_msg  input  p_num_reqs*p_msg_nbits  flattened messages; requester i occupies bits [i*p_msg_nbits +: p_msg_nbits].
- out_val  output  1  buffer holds a message.
- out_rdy  input  1  downstream ready.
- out_msg  output  p_msg_nbits  buffered message.
- out_src  output  clog2(p_num_reqs)  index of the requester that produced out_msg.
- count  output  p_cnt_nbits  messages delivered downstream (out_val && out_rdy).
- done  output  1  registered; high once count >= expected_total.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: out_val=0, out_msg=0, out_src=0, count=0, done=0, priority pointer ptr=0, in_rdy=0.
- Reset mid-operation discards any buffered message; the requester's handshake has already completed, so that message is lost by design.
- Buffer states:
  - EMPTY: out_val=0.
  - FULL: out_val=1.
- can_accept = EMPTY || (FULL && out_rdy).
- Grant: the first i with in_val[i]=1, searching ptr, ptr+1, ... wrapping modulo p_num_reqs.
- in_rdy[i] = grant[i] && can_accept. in_rdy is combinational from in_val, ptr, out_val and out_rdy; there is no path from in_msg.
- Enqueue (in_val[i] && in_rdy[i]):
  - Next cycle: out_val=1, out_msg=in_msg[i], out_src=i.
  - ptr <= (i+1) mod p_num_reqs.
  - Latency is exactly 1 cycle from accept to out_val.
- Dequeue (out_val && out_rdy) with no enqueue: out_val <= 0; out_msg and out_src hold their values.
- Simultaneous dequeue and enqueue in FULL: buffer is replaced; sustained throughput is 1 msg/cycle.
- No request while EMPTY: ptr holds; out_val stays 0.
- FULL && !out_rdy: all in_rdy=0; out_msg and out_src stable (val/rdy hold rule).
- Fairness: with all requesters continuously valid and out_rdy=1, the grant order is 0,1,...,N-1,0,... Each requester waits at most N-1 grants.
- count:
  - Increments by 1 on each dequeue.
  - Saturates at all-ones; it does not wrap.
- done:
  - done <= (count_next >= expected_total), so it asserts in the cycle after the final dequeue.
  - With expected_total=0, done is 1 in the first cycle after reset deasserts.
  - done deasserts if expected_total is raised above count.
- Non-power-of-2 p_num_reqs: ptr wraps from p_num_reqs-1 to 0; ptr never holds an out-of-range index.

Decomposition:
- Shared package constants:
  - function computing clog2 index width from p_num_reqs.
  - localparams for buffer state encodings EMPTY=0 and FULL=1.
- One sub-module, test_rr_arb_core: combinational grant-vector plus winner-index generator from (req vector, ptr), parameterized by p_num_reqs.
- The parent owns ptr, the buffer and the counters.

Test Plan:
- Single requester 2 with msgs 0xA0,0xA1,0xA2, out_rdy=1, expected_total=3 -> out_msg 0xA0,0xA1,0xA2 on consecutive cycles starting 1 cycle after the first accept; out_src=2 each; count=3; done=1 the cycle after the last dequeue.
- All 4 requesters always valid, out_rdy=1, 8 transfers -> out_src sequence 0,1,2,3,0,1,2,3; one transfer per cycle; no in_rdy bit asserted for a non-granted port.
- Buffer full, out_rdy=0 for 5 cycles, then 1 -> out_msg/out_src stable all 5 cycles; in_rdy=0; on release, dequeue and new enqueue in the same cycle.
- p_num_reqs=3, requesters 1 and 2 valid, starting from ptr=2 -> grants 2,1,2,1; ptr wraps 2->0.
- Reset asserted asynchronously with the buffer FULL and count=5 -> out_val, count, done and in_rdy drop to 0 immediately, without waiting for a clock edge; after deassert, the next grant starts from requester 0.
- expected_total=0 after reset -> done=1 on the first post-reset edge; set expected_total=2 -> done=0 until 2 dequeues complete.
